// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Drives a multiplexed 7-segment display (plus decimal point) from a
// small digit buffer.
//
// Each digit gets one slot of REFRESH_DIV clk cycles. A slot begins with
// BLANK_CYC cycles where everything is dark, which stops ghosting while the
// digit drivers switch. The rest of the slot lights the selected digit with
// its stored pattern.
//
// Writes from the producer are independent of the scan position.
// A write to the digit that is lit right now shows on the pins on the next
// cycle.
//
// Optional feature (compile-time macro SEG_SCROLL_EN):
//   undefined : each capture writes buffer[wr_ptr], and wr_ptr then wraps
//               through 0..NUM_DIGITS-1.
//   defined   : each capture shifts the buffer one digit to the left, and
//               the new pattern enters at digit 0. There is no write pointer.
//
// Parameters:
//   BYTE_W      segment pattern width (a-g plus dp)
//   NUM_DIGITS  number of multiplexed digits, 2..8
//   REFRESH_DIV clk cycles per digit slot, at least BLANK_CYC+2
//   BLANK_CYC   dark cycles at the start of each slot, at least 1
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset. It overrides all other inputs.
//   en             block enable. While low, scanning freezes, strobes are
//                  ignored and the outputs are dark.
//   seg_in         segment pattern from the producer
//   seg_ud         one-cycle strobe that captures seg_in
//   seg_clr        one-cycle strobe that blanks every digit. It wins over seg_ud.
//   seg_pins       active-high segment drive (registered)
//   dig_sel        active-high one-hot digit enable (registered)
//   dbg_scan_on_o  scan FSM state (0 = BLANK, 1 = ON)
//
// Handshake: seg_ud and seg_clr are single-cycle strobes qualified by en.
// They have no ready signal. Every strobe seen with en=1 is acted on at that
// edge, so back-to-back strobes are all captured.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int BYTE_W      = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 12000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [BYTE_W-1:0]     seg_in,
  input  logic                  seg_ud,
  input  logic                  seg_clr,
  output logic [BYTE_W-1:0]     seg_pins,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  dbg_scan_on_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  scan_state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [BYTE_W-1:0]     seg_pins_q, seg_pins_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [BYTE_W-1:0]     buf_q [NUM_DIGITS];
  logic [BYTE_W-1:0]     buf_d [NUM_DIGITS];

`ifndef SEG_SCROLL_EN
  logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
`endif

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Scan FSM: next state, refresh counter and scan index.
  // Everything holds while en is low, so scanning resumes exactly where it
  // stopped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_idx_d = scan_idx_q;
    if (en) begin
      cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) state_d = ST_ON;
        end
        ST_ON: begin
          if (cnt_last) begin
            state_d    = ST_BLANK;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-state values.
  // The output register samples the current buffer, so a write to the lit
  // digit reaches the pins one cycle after its capture edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_pins_d = '0;
    dig_sel_d  = '0;
    if (en && (state_q == ST_ON)) begin
      seg_pins_d = buf_q[scan_idx_q];
      dig_sel_d  = DIG_ONE << scan_idx_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit buffer update. A clear wins over a simultaneous capture, and the
  // captured pattern is discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_d = buf_q;
`ifndef SEG_SCROLL_EN
    wr_ptr_d = wr_ptr_q;
`endif
    if (en) begin
      if (seg_clr) begin
        for (int k = 0; k < NUM_DIGITS; k++) buf_d[k] = '0;
`ifndef SEG_SCROLL_EN
        wr_ptr_d = '0;
`endif
      end else if (seg_ud) begin
`ifdef SEG_SCROLL_EN
        // New pattern enters on the right; the leftmost digit falls off.
        buf_d[0] = seg_in;
        for (int k = 1; k < NUM_DIGITS; k++) buf_d[k] = buf_q[k-1];
`else
        buf_d[wr_ptr_q] = seg_in;
        wr_ptr_d        = (wr_ptr_q == IDX_LAST) ? '0 : wr_ptr_q + IW'(1);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      seg_pins_q <= '0;
      dig_sel_q  <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) buf_q[k] <= '0;
`ifndef SEG_SCROLL_EN
      wr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_pins_q <= seg_pins_d;
      dig_sel_q  <= dig_sel_d;
      buf_q      <= buf_d;
`ifndef SEG_SCROLL_EN
      wr_ptr_q   <= wr_ptr_d;
`endif
    end
  end

  assign seg_pins      = seg_pins_q;
  assign dig_sel       = dig_sel_q;
  assign dbg_scan_on_o = (state_q == ST_ON);

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Bench for seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
//
// The reference model tracks the number of enabled cycles since reset.
// From that count it derives the slot (count / REFRESH_DIV mod NUM_DIGITS)
// and the phase inside the slot (count mod REFRESH_DIV). It also keeps a
// plain array copy of the digit buffer.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int BW = 8;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic [BW-1:0] seg_in  = '0;
  logic          seg_ud  = 1'b0;
  logic          seg_clr = 1'b0;
  logic [BW-1:0] seg_pins;
  logic [ND-1:0] dig_sel;
  logic          dbg_scan_on;

  seg_scan_driver #(
    .BYTE_W(BW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in), .seg_ud(seg_ud),
    .seg_clr(seg_clr), .seg_pins(seg_pins), .dig_sel(dig_sel),
    .dbg_scan_on_o(dbg_scan_on)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [BW-1:0] m_buf [ND];
  int            m_wp;
  int            m_t;
  logic [BW-1:0] exp_seg;
  logic [ND-1:0] exp_dig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive the inputs, advance the model, then compare.
  task automatic drive_cycle(input logic r, input logic e, input logic u,
                             input logic c, input logic [BW-1:0] s);
    int slot;
    int ph;
    rst_n = r; en = e; seg_ud = u; seg_clr = c; seg_in = s;
    exp_seg = '0;
    exp_dig = '0;
    if (!r) begin
      for (int k = 0; k < ND; k++) m_buf[k] = '0;
      m_wp = 0;
      m_t  = 0;
    end else if (e) begin
      slot = (m_t / RD) % ND;
      ph   = m_t % RD;
      if (ph >= BC) begin
        exp_dig = ND'(1) << slot;
        exp_seg = m_buf[slot];
      end
      if (c) begin
        for (int k = 0; k < ND; k++) m_buf[k] = '0;
        m_wp = 0;
      end else if (u) begin
`ifdef SEG_SCROLL_EN
        for (int k = ND - 1; k > 0; k--) m_buf[k] = m_buf[k-1];
        m_buf[0] = s;
`else
        m_buf[m_wp] = s;
        m_wp = (m_wp + 1) % ND;
`endif
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    chk("seg_pins", 32'(seg_pins), 32'(exp_seg));
    chk("dig_sel", 32'(dig_sel), 32'(exp_dig));
    chk("dig_sel_onehot", 32'($countones(dig_sel) <= 1), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  // Run idle cycles until dig_sel equals target, with a bounded cycle budget.
  task automatic wait_dig(input logic [ND-1:0] target, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (dig_sel == target) found = 1'b1;
    end
    chk("wait_dig_timeout", 32'(found), 32'd1);
  endtask

  // Visit each digit's ON slot and compare the pattern it shows.
  task automatic check_slots(input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                             input logic [BW-1:0] e2, input logic [BW-1:0] e3);
    logic [BW-1:0] ev [ND];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int d = 0; d < ND; d++) begin
      wait_dig(ND'(1) << d, 4 * RD);
      chk($sformatf("slot%0d_pattern", d), 32'(seg_pins), 32'(ev[d]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r, e, u, c;
    logic [BW-1:0] s;
    logic [BW-1:0] xs;
    logic [ND-1:0] xd;
  } vec_t;

  vec_t tab [13];

  logic [ND-1:0] exp_q [$];
  logic [ND-1:0] got_q [$];

  initial begin
    logic [BW-1:0] t3, t4, t5, t11;
    logic [ND-1:0] prev;
    int cnt_on;
    int k_first;

`ifdef SEG_SCROLL_EN
    t3 = 8'h06; t4 = 8'h5B; t5 = 8'h4F; t11 = 8'h5B;
`else
    t3 = 8'h3F; t4 = 8'h3F; t5 = 8'h3F; t11 = 8'h06;
`endif
    //            r     e     u     c     s      xs     xd
    tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
    tab[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h3F, 8'h00, 4'b0000};
    tab[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h06, 8'h00, 4'b0000};
    tab[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5B, t3,    4'b0001};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h4F, t4,    4'b0001};
    tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t5,    4'b0001};
    tab[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t5,    4'b0001};
    tab[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t5,    4'b0001};
    tab[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t5,    4'b0001};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
    tab[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
    tab[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, t11,   4'b0010};
    tab[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h66, t11,   4'b0010};

    for (int k = 0; k < ND; k++) m_buf[k] = '0;
    m_wp = 0;
    m_t  = 0;

    // ---- reset, then free-running scan with an empty buffer ----
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev = '0;
    for (int i = 0; i < 5 * RD; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (dig_sel != '0 && prev == '0 && got_q.size() < 5) got_q.push_back(dig_sel);
      prev = dig_sel;
    end
    chk("scan_order_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("scan_order_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    // ---- vector table: reset, four back-to-back writes, fifth write ----
    for (int i = 0; i < 13; i++) begin
      drive_cycle(tab[i].r, tab[i].e, tab[i].u, tab[i].c, tab[i].s);
      chk($sformatf("tab%0d_seg", i), 32'(seg_pins), 32'(tab[i].xs));
      chk($sformatf("tab%0d_dig", i), 32'(dig_sel), 32'(tab[i].xd));
    end
`ifdef SEG_SCROLL_EN
    check_slots(8'h66, 8'h4F, 8'h5B, 8'h06);
`else
    check_slots(8'h66, 8'h06, 8'h5B, 8'h4F);
`endif

    // ---- clear and write on the same cycle: clear wins ----
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h7F);
    check_slots(8'h00, 8'h00, 8'h00, 8'h00);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
    check_slots(8'hA5, 8'h00, 8'h00, 8'h00);

    // ---- en dropped mid-ON for digit 2 ----
    wait_dig(4'b0100, 4 * RD);
    cnt_on = 1;
    idle(2);
    cnt_on += 2;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("en_low_dark", 32'(dig_sel), 32'd0);
    for (int i = 0; i < RD; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (dig_sel == 4'b0100) cnt_on++;
      else break;
    end
    chk("digit2_on_total", 32'(cnt_on), 32'd6);

    // ---- reset during digit 3 ON together with a strobe ----
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
    wait_dig(4'b1000, 4 * RD);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    k_first = 0;
    for (int k = 1; k <= 3 * BC + 4 && k_first == 0; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (dig_sel != '0) k_first = k;
    end
    chk("post_reset_first_on_delay", 32'(k_first), 32'(BC + 1));
    chk("post_reset_first_digit", 32'(dig_sel), 32'd1);
    chk("post_reset_pattern", 32'(seg_pins), 32'd0);
    check_slots(8'h00, 8'h00, 8'h00, 8'h00);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                  BW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
